mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_BIT_COUNT, 9, macro address width; WORD_SIZE, 32, data width; Q_DEPTH, 4, command and response queue depth (power of 2).
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  input  1  host command valid.
REQ-005 REQ_READY  output  1  command queue can accept.
REQ-006 REQ_WE  input  1  1 = write, 0 = read.
REQ-007 REQ_ADDR  input  ADDR_BIT_COUNT  command address.
REQ-008 REQ_WDATA  input  WORD_SIZE  write data.
REQ-009 RSP_VALID  output  1  read data available.
REQ-010 RSP_READY  input  1  host accepts read data.
REQ-011 RSP_RDATA  output  WORD_SIZE  read data, in request order.
REQ-012 CE, WE  output  1 each  registered macro chip-enable and write-enable.
REQ-013 ADDR  output  ADDR_BIT_COUNT  registered macro address.
REQ-014 DIN  output  WORD_SIZE  registered macro write data.
REQ-015 DOUT  input  WORD_SIZE  macro read data, already bank-muxed.
REQ-016 BUSY  output  1  high while any queue is non-empty or any read is in flight.

Function
REQ-017 A command SHALL be accepted on an edge with REQ_VALID&&REQ_READY; REQ_READY = command queue not full; there is no push-while-full pass-through, even with a simultaneous pop.
REQ-018 The command queue SHALL be a FIFO of {WE, ADDR, WDATA}, Q_DEPTH entries, with pointers wrapping modulo Q_DEPTH and a count width of log2(Q_DEPTH)+1.
REQ-019 The FSM SHALL have two states: IDLE (CE=0) and ISSUE. IDLE->ISSUE when the queue is non-empty and the head is issuable. ISSUE->IDLE when no issuable head exists at the edge.
REQ-020 A write head SHALL always be issuable. A read head SHALL be issuable only if (response count + reads in flight) < Q_DEPTH.
REQ-021 On the issue edge T, the head SHALL be popped and CE=1, WE=head.WE, ADDR=head.ADDR, and DIN=head.WDATA (DIN=0 for reads) SHALL be registered. One command SHALL be issued per cycle, back-to-back.
REQ-022 On an edge with no issue, CE and WE SHALL go to 0, while ADDR and DIN hold their previous values.
REQ-023 A read issued at edge T SHALL be sampled by the macro at T+1, and DOUT SHALL be captured into the response queue at edge T+2. The in-flight tracker SHALL be a 2-stage valid shift register, so at most 2 reads are in flight.
REQ-024 Latency: a read accepted at edge A into an empty, idle block SHALL issue at A+1, capture at A+3, and show RSP_VALID=1 after A+3.
REQ-025 The response queue SHALL be a FIFO, Q_DEPTH deep. RSP_VALID = not empty. RSP_RDATA = head entry. The queue SHALL pop on RSP_VALID&&RSP_READY.
REQ-026 A simultaneous capture and pop SHALL leave the count unchanged. The credit rule (REQ-020) SHALL guarantee that a capture never finds the queue full.
REQ-027 Writes SHALL produce no response. Mixed sequences SHALL issue in strict acceptance order, and a stalled read head SHALL block later writes.
REQ-028 BUSY = command count != 0 || response count != 0 || any in-flight valid bit.

Reset
REQ-029 While RST=1, the block SHALL force CE=0, WE=0, ADDR=0, DIN=0, RSP_VALID=0, RSP_RDATA=0, REQ_READY=0, BUSY=0, FSM=IDLE, all counts/pointers/in-flight bits=0.
REQ-030 After RST deasserts, REQ_READY SHALL be 1 from the first edge.
REQ-031 A reset mid-operation SHALL discard queued commands, in-flight reads and responses without emitting partial responses.

Verification
REQ-032 Single write: write ADDR=0x1A5, WDATA=0xDEADBEEF accepted at edge 0 -> the CE=1, WE=1, ADDR=0x1A5, DIN=0xDEADBEEF cycle starts at edge 1; CE=0 from edge 2; RSP_VALID stays 0.
REQ-033 Read latency: read ADDR=0x003 accepted at edge 0, DOUT model returns 0x12345678 -> CE=1, WE=0 from edge 1; RSP_VALID=1 with RSP_RDATA=0x12345678 after edge 3.
REQ-034 Credit stall: RSP_READY=0, issue 6 reads -> exactly 4 reads are issued, CE stays 0 afterwards, and 2 commands remain queued. Raising RSP_READY for 1 cycle -> exactly 1 further read issues.
REQ-035 Full queue: hold the macro stalled as in REQ-034 and push until REQ_READY=0 -> a push attempted on the same edge as a pop is not accepted, and the count is unchanged afterwards.
REQ-036 Ordering: sequence W(0x010,A), R(0x010), W(0x011,B), R(0x011) -> the issue order on ADDR matches, and responses arrive in order.
REQ-037 Reset mid-flight: assert RST one cycle after a read issues -> all outputs are 0 immediately, and no RSP_VALID occurs after release.

Source files
------------

// File: rtl/mem_req_ctrl_if.sv
// Host command/response handshake plus the registered macro bus of mem_req_ctrl.
// slave = controller side, master = host/macro side.
interface mem_req_ctrl_if #(
  parameter int unsigned ADDR_BIT_COUNT = 9,
  parameter int unsigned WORD_SIZE      = 32
);
  logic                      REQ_VALID;
  logic                      REQ_READY;
  logic                      REQ_WE;
  logic [ADDR_BIT_COUNT-1:0] REQ_ADDR;
  logic [WORD_SIZE-1:0]      REQ_WDATA;
  logic                      RSP_VALID;
  logic                      RSP_READY;
  logic [WORD_SIZE-1:0]      RSP_RDATA;
  logic                      CE;
  logic                      WE;
  logic [ADDR_BIT_COUNT-1:0] ADDR;
  logic [WORD_SIZE-1:0]      DIN;
  logic [WORD_SIZE-1:0]      DOUT;
  logic                      BUSY;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY, DOUT,
    output REQ_READY, RSP_VALID, RSP_RDATA, CE, WE, ADDR, DIN, BUSY
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY, DOUT,
    input  REQ_READY, RSP_VALID, RSP_RDATA, CE, WE, ADDR, DIN, BUSY
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Memory request controller: queues host commands, issues them to a single-port
// macro one per cycle, and returns read data in order through a credited response queue.
module mem_req_ctrl #(
  parameter int unsigned ADDR_BIT_COUNT = 9,
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned Q_DEPTH        = 4
) (
  input logic           CLK,
  input logic           RST,
  mem_req_ctrl_if.slave bus
);
  localparam int unsigned PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;

  logic                      cmd_we_q    [Q_DEPTH];
  logic [ADDR_BIT_COUNT-1:0] cmd_addr_q  [Q_DEPTH];
  logic [WORD_SIZE-1:0]      cmd_wdata_q [Q_DEPTH];
  logic [PW-1:0]             cmd_wr_ptr, cmd_rd_ptr;
  logic [CW-1:0]             cmd_count;

  logic [WORD_SIZE-1:0]      rsp_data_q [Q_DEPTH];
  logic [PW-1:0]             rsp_wr_ptr, rsp_rd_ptr;
  logic [CW-1:0]             rsp_count;

  logic [1:0]                inflight;
  logic                      ce_q, we_q;
  logic [ADDR_BIT_COUNT-1:0] addr_q;
  logic [WORD_SIZE-1:0]      din_q;

  logic                      cmd_full, cmd_empty, cmd_push;
  logic                      rsp_empty, rsp_push, rsp_pop;
  logic                      head_we;
  logic [ADDR_BIT_COUNT-1:0] head_addr;
  logic [WORD_SIZE-1:0]      head_wdata;
  logic [SW-1:0]             credit_used;
  logic                      issue;

  always_comb begin
    cmd_full    = (cmd_count == CW'(Q_DEPTH));
    cmd_empty   = (cmd_count == '0);
    rsp_empty   = (rsp_count == '0);
    head_we     = cmd_we_q[cmd_rd_ptr];
    head_addr   = cmd_addr_q[cmd_rd_ptr];
    head_wdata  = cmd_wdata_q[cmd_rd_ptr];
    // Reads in flight already own a response slot, so a capture can never overflow.
    credit_used = SW'(rsp_count) + SW'(inflight[0]) + SW'(inflight[1]);
    issue       = !cmd_empty && (head_we || (credit_used < SW'(Q_DEPTH)));
    cmd_push    = bus.REQ_VALID && !cmd_full && !RST;
    rsp_push    = inflight[1];
    rsp_pop     = !rsp_empty && bus.RSP_READY;
  end

  assign bus.REQ_READY = !cmd_full && !RST;
  assign bus.RSP_VALID = !rsp_empty;
  assign bus.RSP_RDATA = rsp_empty ? '0 : rsp_data_q[rsp_rd_ptr];
  assign bus.BUSY      = !cmd_empty || !rsp_empty || (inflight != '0);
  assign bus.CE        = ce_q;
  assign bus.WE        = we_q;
  assign bus.ADDR      = addr_q;
  assign bus.DIN       = din_q;

  always_ff @(posedge CLK) begin
    if (cmd_push) begin
      cmd_we_q[cmd_wr_ptr]    <= bus.REQ_WE;
      cmd_addr_q[cmd_wr_ptr]  <= bus.REQ_ADDR;
      cmd_wdata_q[cmd_wr_ptr] <= bus.REQ_WDATA;
    end
    if (rsp_push) begin
      rsp_data_q[rsp_wr_ptr] <= bus.DOUT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
      if (issue)    cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
      case ({cmd_push, issue})
        2'b10:   cmd_count <= cmd_count + CW'(1);
        2'b01:   cmd_count <= cmd_count - CW'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
      inflight   <= '0;
    end else begin
      inflight <= {inflight[0], issue && !head_we};
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + CW'(1);
        2'b01:   rsp_count <= rsp_count - CW'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      ce_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      case (state)
        IDLE:    if (issue)  state <= ISSUE;
        ISSUE:   if (!issue) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (issue) begin
        ce_q   <= 1'b1;
        we_q   <= head_we;
        addr_q <= head_addr;
        din_q  <= head_we ? head_wdata : '0;
      end else begin
        ce_q <= 1'b0;
        we_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with a behavioural single-port macro model.
module tb_mem_req_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_req_ctrl_if #(.ADDR_BIT_COUNT(9), .WORD_SIZE(32)) bus ();

  mem_req_ctrl #(.ADDR_BIT_COUNT(9), .WORD_SIZE(32), .Q_DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Macro model: write on CE&WE, registered read on CE&!WE; unwritten words have a fixed pattern.
  logic [31:0] mem     [512];
  logic        written [512];
  always @(posedge CLK) begin
    if (bus.CE && bus.WE) begin
      mem[bus.ADDR]     <= bus.DIN;
      written[bus.ADDR] <= 1'b1;
    end else if (bus.CE) begin
      bus.DOUT <= (written[bus.ADDR] === 1'b1) ? mem[bus.ADDR]
                                               : (32'h12345678 ^ {23'd0, bus.ADDR ^ 9'h003});
    end
  end

  int          n_iss = 0;
  logic [8:0]  iss_addr [16];
  logic        iss_we   [16];
  int          n_rsp = 0;
  logic [31:0] rsp_log  [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample outputs 1ns later and log issues / accepted responses.
  task automatic step();
    @(posedge CLK);
    #1;
    if (bus.CE === 1'b1) begin
      if (n_iss < 16) begin
        iss_addr[n_iss] = bus.ADDR;
        iss_we[n_iss]   = bus.WE;
      end
      n_iss++;
    end
    if (bus.RSP_VALID === 1'b1 && bus.RSP_READY === 1'b1) begin
      if (n_rsp < 16) rsp_log[n_rsp] = bus.RSP_RDATA;
      n_rsp++;
    end
  endtask

  task automatic drive_cmd(input logic we, input logic [8:0] addr, input logic [31:0] wdata);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
  endtask

  initial begin
    int base;
    int seen;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;
    bus.RSP_READY = 1'b0;
    bus.DOUT      = '0;
    for (int i = 0; i < 512; i++) written[i] = 1'b0;

    // Reset state
    #2;
    chk("rst_ce", 64'(bus.CE), 64'd0);
    chk("rst_we", 64'(bus.WE), 64'd0);
    chk("rst_addr", 64'(bus.ADDR), 64'd0);
    chk("rst_din", 64'(bus.DIN), 64'd0);
    chk("rst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.RSP_RDATA), 64'd0);
    chk("rst_req_ready", 64'(bus.REQ_READY), 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    step();
    step();
    RST = 1'b0;
    step();
    chk("post_rst_ready", 64'(bus.REQ_READY), 64'd1);

    // Single write
    drive_cmd(1'b1, 9'h1A5, 32'hDEADBEEF);
    step();
    bus.REQ_VALID = 1'b0;
    chk("wr_ce_e0", 64'(bus.CE), 64'd0);
    chk("wr_busy_e0", 64'(bus.BUSY), 64'd1);
    step();
    chk("wr_ce_e1", 64'(bus.CE), 64'd1);
    chk("wr_we_e1", 64'(bus.WE), 64'd1);
    chk("wr_addr_e1", 64'(bus.ADDR), 64'h1A5);
    chk("wr_din_e1", 64'(bus.DIN), 64'hDEADBEEF);
    step();
    chk("wr_ce_e2", 64'(bus.CE), 64'd0);
    chk("wr_we_e2", 64'(bus.WE), 64'd0);
    chk("wr_addr_hold", 64'(bus.ADDR), 64'h1A5);
    chk("wr_din_hold", 64'(bus.DIN), 64'hDEADBEEF);
    chk("wr_no_rsp", 64'(bus.RSP_VALID), 64'd0);

    // Read latency
    drive_cmd(1'b0, 9'h003, 32'h0);
    step();
    bus.REQ_VALID = 1'b0;
    step();
    chk("rd_ce_e1", 64'(bus.CE), 64'd1);
    chk("rd_we_e1", 64'(bus.WE), 64'd0);
    chk("rd_addr_e1", 64'(bus.ADDR), 64'h003);
    chk("rd_din_e1", 64'(bus.DIN), 64'd0);
    chk("rd_busy_e1", 64'(bus.BUSY), 64'd1);
    step();
    chk("rd_rsp_e2", 64'(bus.RSP_VALID), 64'd0);
    step();
    chk("rd_rsp_e3", 64'(bus.RSP_VALID), 64'd1);
    chk("rd_rdata_e3", 64'(bus.RSP_RDATA), 64'h12345678);
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    chk("rd_popped", 64'(bus.RSP_VALID), 64'd0);
    chk("rd_idle_busy", 64'(bus.BUSY), 64'd0);

    // Credit stall: six reads with responses held back
    base = n_iss;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(1'b0, 9'(9'h020 + i), 32'h0);
      step();
    end
    bus.REQ_VALID = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("stall_issued", 64'(n_iss - base), 64'd4);
    chk("stall_ce", 64'(bus.CE), 64'd0);
    chk("stall_queued", 64'(dut.cmd_count), 64'd2);
    chk("stall_head", 64'(bus.RSP_RDATA), 64'h1234565B);
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    chk("credit_next_head", 64'(bus.RSP_RDATA), 64'h1234565A);
    for (int i = 0; i < 6; i++) step();
    chk("credit_one_more", 64'(n_iss - base), 64'd5);
    chk("credit_addr", 64'(iss_addr[base + 4]), 64'h024);

    // Full command queue: a push on the same edge as a pop is refused
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b0, 9'(9'h030 + i), 32'h0);
      step();
    end
    chk("full_ready", 64'(bus.REQ_READY), 64'd0);
    chk("full_count", 64'(dut.cmd_count), 64'd4);
    drive_cmd(1'b0, 9'h03F, 32'h0);
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    step();
    bus.REQ_VALID = 1'b0;
    chk("full_pop_issue", 64'(bus.CE), 64'd1);
    chk("full_pop_addr", 64'(bus.ADDR), 64'h025);
    chk("full_no_push", 64'(dut.cmd_count), 64'd3);
    chk("full_ready_back", 64'(bus.REQ_READY), 64'd1);

    bus.RSP_READY = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("drain_busy", 64'(bus.BUSY), 64'd0);
    chk("drain_no_3f", 64'(iss_addr[n_iss - 1]), 64'h032);

    // Ordering across mixed writes and reads
    base = n_iss;
    n_rsp = 0;
    drive_cmd(1'b1, 9'h010, 32'hAAAA0001);
    step();
    drive_cmd(1'b0, 9'h010, 32'h0);
    step();
    drive_cmd(1'b1, 9'h011, 32'hBBBB0002);
    step();
    drive_cmd(1'b0, 9'h011, 32'h0);
    step();
    bus.REQ_VALID = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("ord_count", 64'(n_iss - base), 64'd4);
    chk("ord_a0", 64'({iss_we[base], iss_addr[base]}), 64'h210);
    chk("ord_a1", 64'({iss_we[base + 1], iss_addr[base + 1]}), 64'h010);
    chk("ord_a2", 64'({iss_we[base + 2], iss_addr[base + 2]}), 64'h211);
    chk("ord_a3", 64'({iss_we[base + 3], iss_addr[base + 3]}), 64'h011);
    chk("ord_rsp_n", 64'(n_rsp), 64'd2);
    chk("ord_rsp0", 64'(rsp_log[0]), 64'hAAAA0001);
    chk("ord_rsp1", 64'(rsp_log[1]), 64'hBBBB0002);

    // Reset one cycle after a read issues
    drive_cmd(1'b0, 9'h040, 32'h0);
    step();
    bus.REQ_VALID = 1'b0;
    step();
    chk("mid_issue", 64'(bus.CE), 64'd1);
    step();
    RST = 1'b1;
    #1;
    chk("mid_rst_ce", 64'(bus.CE), 64'd0);
    chk("mid_rst_addr", 64'(bus.ADDR), 64'd0);
    chk("mid_rst_busy", 64'(bus.BUSY), 64'd0);
    chk("mid_rst_ready", 64'(bus.REQ_READY), 64'd0);
    chk("mid_rst_rsp", 64'(bus.RSP_VALID), 64'd0);
    step();
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.RSP_VALID !== 1'b0) seen++;
    end
    chk("mid_no_rsp", 64'(seen), 64'd0);
    chk("mid_busy_after", 64'(bus.BUSY), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
